// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle between the three execution units and the
// arbiter: per-requester valid/rd/data in, one-hot ready back.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic [2:0]           req_valid_i;
  logic [2:0][4:0]      req_rd_i;
  logic [2:0][XLEN-1:0] req_data_i;
  logic [2:0]           req_ready_o;

  modport master (
    output req_valid_i,
    output req_rd_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_rd_i,
    input  req_data_i,
    output req_ready_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for ALU/LSU/MDU (bits 0/1/2) feeding one
// register file write port through a single registered output stage.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  regfile_wb_arbiter_if.slave req,
  input  logic                wb_stall_i,
  output logic                reg_write_o,
  output logic [4:0]          rd_o,
  output logic [XLEN-1:0]     rd_din_o
);

  logic [1:0]      ptr_reg;
  logic [1:0]      ptr_next;
  logic [1:0]      ptr_eff;
  logic [2:0]      blocked;
  logic [2:0]      grant;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] din_reg;

  // The unused pointer code 3 behaves as 0 so the grant stays one-hot.
  assign ptr_eff = (ptr_reg == 2'd3) ? 2'd0 : ptr_reg;

  // Requester gi loses only to valid requesters that precede it in the
  // search order starting at ptr.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_prio
      localparam logic [1:0] PREV1 = 2'((gi + 2) % 3);
      localparam logic [1:0] PREV2 = 2'((gi + 1) % 3);

      assign blocked[gi] = ((ptr_eff == PREV1) && req.req_valid_i[PREV1]) ||
                           ((ptr_eff == PREV2) &&
                            (req.req_valid_i[PREV2] || req.req_valid_i[PREV1]));
      assign grant[gi]   = rst_ni && !wb_stall_i && req.req_valid_i[gi] &&
                           !blocked[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= 2'd0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  always_comb begin
    ptr_next = ptr_eff;
    case (grant)
      3'b001:  ptr_next = 2'd1;
      3'b010:  ptr_next = 2'd2;
      3'b100:  ptr_next = 2'd0;
      default: ptr_next = ptr_eff;
    endcase
  end

  always_comb begin
    req.req_ready_o = grant;
    sel_rd          = '0;
    sel_data        = '0;
    for (int k = 0; k < 3; k++) begin
      if (grant[k]) begin
        sel_rd   = sel_rd | req.req_rd_i[k];
        sel_data = sel_data | req.req_data_i[k];
      end
    end
  end

  // Writes to x0 are consumed but leave a zeroed, disabled output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_reg  <= 1'b0;
      rd_reg  <= '0;
      din_reg <= '0;
    end else if (|grant) begin
      wr_reg  <= (sel_rd != 5'd0);
      rd_reg  <= sel_rd;
      din_reg <= (sel_rd != 5'd0) ? sel_data : '0;
    end else begin
      wr_reg  <= 1'b0;
    end
  end

  assign reg_write_o = wr_reg;
  assign rd_o        = rd_reg;
  assign rd_din_o    = din_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run against a round-robin search model.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk_i;
  logic            rst_ni;
  logic            wb_stall_i;
  logic            reg_write_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] rd_din_o;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req         (bus),
    .wb_stall_i  (wb_stall_i),
    .reg_write_o (reg_write_o),
    .rd_o        (rd_o),
    .rd_din_o    (rd_din_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]      valid;
    logic            stall;
    logic [2:0][4:0] rd;
    logic [2:0][31:0] data;
    logic [2:0]      e_ready;
    logic            e_wr;
    logic [4:0]      e_rd;
    logic [31:0]     e_data;
  } vec_t;

  int          n_checks;
  int          n_fail;
  int          m_ptr;
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          wait_cnt [3];
  vec_t        tbl [10];

  function automatic logic [2:0][4:0] rds(input logic [4:0] a, b, c);
    logic [2:0][4:0] ret;
    ret[0] = a; ret[1] = b; ret[2] = c;
    return ret;
  endfunction

  function automatic logic [2:0][31:0] dts(input logic [31:0] a, b, c);
    logic [2:0][31:0] ret;
    ret[0] = a; ret[1] = b; ret[2] = c;
    return ret;
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input logic s,
                              input logic [2:0][4:0] r, input logic [2:0][31:0] d,
                              input logic [2:0] er, input logic ew,
                              input logic [4:0] erd, input logic [31:0] ed);
    vec_t t;
    t.valid = v; t.stall = s; t.rd = r; t.data = d;
    t.e_ready = er; t.e_wr = ew; t.e_rd = erd; t.e_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: scan requesters from ptr with wraparound, first valid wins.
  task automatic model_step(input logic [2:0] v, input logic s,
                            input logic [2:0][4:0] r, input logic [2:0][31:0] d,
                            output logic [2:0] e_ready);
    int g;
    int k;
    g = -1;
    if (!s) begin
      for (int i = 0; i < 3; i++) begin
        k = (m_ptr + i) % 3;
        if (g < 0 && v[k]) g = k;
      end
    end
    if (g >= 0) begin
      e_ready = 3'(1 << g);
      m_wr    = (r[g] != 5'd0);
      m_rd    = r[g];
      m_data  = (r[g] != 5'd0) ? d[g] : 32'd0;
      m_ptr   = (g + 1) % 3;
    end else begin
      e_ready = 3'b000;
      m_wr    = 1'b0;
    end
  endtask

  task automatic run_cycle(input logic [2:0] v, input logic s,
                           input logic [2:0][4:0] r, input logic [2:0][31:0] d,
                           input bit use_exp, input logic [2:0] x_ready,
                           input logic x_wr, input logic [4:0] x_rd,
                           input logic [31:0] x_data, input string tag);
    logic [2:0]  m_ready;
    logic [2:0]  e_ready;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bus.req_valid_i = v;
    bus.req_rd_i    = r;
    bus.req_data_i  = d;
    wb_stall_i      = s;
    model_step(v, s, r, d, m_ready);
    if (use_exp) begin
      e_ready = x_ready; e_wr = x_wr; e_rd = x_rd; e_data = x_data;
    end else begin
      e_ready = m_ready; e_wr = m_wr; e_rd = m_rd; e_data = m_data;
    end
    #1;
    chk({tag, " ready"}, 32'(bus.req_ready_o), 32'(e_ready));
    if (!s) begin
      for (int k = 0; k < 3; k++) begin
        if (v[k] && !bus.req_ready_o[k]) begin
          wait_cnt[k]++;
          chk($sformatf("%s starve%0d", tag, k), 32'(wait_cnt[k] < 3), 32'd1);
        end else begin
          wait_cnt[k] = 0;
        end
      end
    end
    @(posedge clk_i);
    #1;
    chk({tag, " reg_write"}, 32'(reg_write_o), 32'(e_wr));
    chk({tag, " rd"}, 32'(rd_o), 32'(e_rd));
    chk({tag, " rd_din"}, rd_din_o, e_data);
    $display("[%0t] %s valid=%b stall=%b ready=%b wr=%b rd=%0d din=0x%08h",
             $time, tag, v, s, e_ready, reg_write_o, rd_o, rd_din_o);
  endtask

  // Asserts reset away from any edge so the output drop is seen asynchronously.
  task automatic do_reset();
    rst_ni          = 1'b0;
    bus.req_valid_i = 3'b111;
    bus.req_rd_i    = rds(5'd9, 5'd10, 5'd11);
    bus.req_data_i  = dts(32'h1, 32'h2, 32'h3);
    wb_stall_i      = 1'b0;
    #1;
    chk("reset async reg_write", 32'(reg_write_o), 32'd0);
    chk("reset async rd", 32'(rd_o), 32'd0);
    chk("reset async rd_din", rd_din_o, 32'd0);
    chk("reset ready", 32'(bus.req_ready_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("reset held reg_write", 32'(reg_write_o), 32'd0);
    chk("reset held ready", 32'(bus.req_ready_o), 32'd0);
    rst_ni = 1'b1;
    m_ptr = 0; m_wr = 1'b0; m_rd = '0; m_data = '0;
    for (int k = 0; k < 3; k++) wait_cnt[k] = 0;
  endtask

  initial begin
    logic [2:0]  g_seq  [4];
    logic [4:0]  rd_seq [4];
    logic [31:0] d_seq  [4];
    logic [2:0]  rv;
    logic        rs;
    logic [2:0][4:0]  rr;
    logic [2:0][31:0] rdat;

    n_checks = 0;
    n_fail   = 0;
    rst_ni          = 1'b0;
    wb_stall_i      = 1'b0;
    bus.req_valid_i = '0;
    bus.req_rd_i    = '0;
    bus.req_data_i  = '0;

    tbl[0] = mk(3'b001, 0, rds(5, 0, 0), dts(32'hDEADBEEF, 0, 0), 3'b001, 1, 5, 32'hDEADBEEF);
    tbl[1] = mk(3'b000, 0, rds(9, 9, 9), dts(32'hFFFF, 32'hFFFF, 32'hFFFF), 3'b000, 0, 5, 32'hDEADBEEF);
    tbl[2] = mk(3'b111, 0, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 3'b010, 1, 2, 32'h22);
    tbl[3] = mk(3'b111, 0, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 3'b100, 1, 3, 32'h33);
    tbl[4] = mk(3'b111, 0, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 3'b001, 1, 1, 32'h11);
    tbl[5] = mk(3'b111, 1, rds(4, 4, 4), dts(32'h44, 32'h44, 32'h44), 3'b000, 0, 1, 32'h11);
    tbl[6] = mk(3'b010, 0, rds(0, 0, 0), dts(0, 32'h1234, 0), 3'b010, 0, 0, 32'h0);
    tbl[7] = mk(3'b101, 0, rds(7, 0, 7), dts(32'hA, 0, 32'hB), 3'b100, 1, 7, 32'hB);
    tbl[8] = mk(3'b101, 0, rds(7, 0, 7), dts(32'hA, 0, 32'hB), 3'b001, 1, 7, 32'hA);
    tbl[9] = mk(3'b000, 0, rds(0, 0, 0), dts(0, 0, 0), 3'b000, 0, 7, 32'hA);

    @(posedge clk_i);
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(tbl[i].valid, tbl[i].stall, tbl[i].rd, tbl[i].data, 1'b1,
                tbl[i].e_ready, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_data,
                $sformatf("tbl%0d", i));
    end

    // All three valid from reset: strict rotation with no bubbles.
    do_reset();
    g_seq  = '{3'b001, 3'b010, 3'b100, 3'b001};
    rd_seq = '{5'd1, 5'd2, 5'd3, 5'd1};
    d_seq  = '{32'h111, 32'h222, 32'h333, 32'h111};
    for (int i = 0; i < 4; i++) begin
      run_cycle(3'b111, 0, rds(1, 2, 3), dts(32'h111, 32'h222, 32'h333), 1'b1,
                g_seq[i], 1'b1, rd_seq[i], d_seq[i], $sformatf("rr%0d", i));
    end

    // Reset while a write is on the outputs, then ALU first.
    do_reset();
    run_cycle(3'b001, 0, rds(5, 0, 0), dts(32'hCAFE, 0, 0), 1'b1,
              3'b001, 1, 5, 32'hCAFE, "pre_rst");
    do_reset();
    run_cycle(3'b111, 0, rds(4, 5, 6), dts(32'h4, 32'h5, 32'h6), 1'b1,
              3'b001, 1, 4, 32'h4, "post_rst");

    // Same rd from ALU and MDU is serialized, not merged.
    do_reset();
    run_cycle(3'b101, 0, rds(7, 0, 7), dts(32'hA, 0, 32'hB), 1'b1,
              3'b001, 1, 7, 32'hA, "same_rd0");
    run_cycle(3'b101, 0, rds(7, 0, 7), dts(32'hA, 0, 32'hB), 1'b1,
              3'b100, 1, 7, 32'hB, "same_rd1");

    // Two stalled cycles leave ptr alone; LSU is next afterwards.
    do_reset();
    run_cycle(3'b111, 0, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 1'b1,
              3'b001, 1, 1, 32'h11, "stall_pre");
    run_cycle(3'b111, 1, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 1'b1,
              3'b000, 0, 1, 32'h11, "stall0");
    run_cycle(3'b111, 1, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 1'b1,
              3'b000, 0, 1, 32'h11, "stall1");
    run_cycle(3'b111, 0, rds(1, 2, 3), dts(32'h11, 32'h22, 32'h33), 1'b1,
              3'b010, 1, 2, 32'h22, "stall_post");

    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 3; k++) begin
        rr[k]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rdat[k] = $urandom;
      end
      run_cycle(rv, rs, rr, rdat, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0,
                $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
